// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM frame constants and types
package tdm_pkg;

  localparam int NUM_SLOTS = 8;

  typedef logic [2:0] slot_t;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - 3-bit wrapping slot pointer
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_to_one,
  input  logic  inc,
  output slot_t slot
);

  // Slot pointer: clr_to_one restarts a frame after its slot-0 write, inc wraps 7->0.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (clr_to_one) begin
      slot <= slot_t'(1);
    end else if (inc) begin
      slot <= slot + slot_t'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_1x8.sv
// rtl/tdm_demux_1x8.sv - 1:8 TDM receive demultiplexer with sync lock
module tdm_demux_1x8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  input  logic             sync,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D3,
  output logic [WIDTH-1:0] D4,
  output logic [WIDTH-1:0] D5,
  output logic [WIDTH-1:0] D6,
  output logic [WIDTH-1:0] D7,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [2:0]       slot,
  output logic             locked
);

  state_t           state;
  slot_t            cur_slot;
  logic [WIDTH-1:0] shadow [NUM_SLOTS-1];
  logic [WIDTH-1:0] d_q    [NUM_SLOTS];

  logic  lock_beat;
  logic  run_beat;
  logic  err_beat;
  logic  restart;
  logic  advance;
  logic  publish;
  slot_t wr_slot;

  // Beat classification: a sync beat in HUNT or a mid-frame sync both restart at slot 0.
  always_comb begin
    lock_beat = (state == HUNT) && valid && sync;
    run_beat  = (state == RUN) && valid;
    err_beat  = run_beat && sync && (cur_slot != '0);
    restart   = lock_beat || err_beat;
    advance   = run_beat && !err_beat;
    publish   = advance && (cur_slot == slot_t'(NUM_SLOTS - 1));
    wr_slot   = restart ? slot_t'(0) : cur_slot;
  end

  tdm_slot_counter u_slot_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_to_one (restart),
    .inc        (advance),
    .slot       (cur_slot)
  );

  // Lock state: enter RUN on the first synced beat, leave only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else if (lock_beat) begin
      state <= RUN;
    end
  end

  // Shadow file for slots 0..6; slot 7 goes straight to the publish registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) shadow[i] <= '0;
    end else if (restart || advance) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if (wr_slot == slot_t'(i)) shadow[i] <= din;
      end
    end
  end

  // Publish a complete frame atomically on the slot-7 write and flag the pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) d_q[i] <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= publish;
      sync_err    <= err_beat;
      if (publish) begin
        for (int i = 0; i < NUM_SLOTS - 1; i++) d_q[i] <= shadow[i];
        d_q[NUM_SLOTS-1] <= din;
      end
    end
  end

  assign D0     = d_q[0];
  assign D1     = d_q[1];
  assign D2     = d_q[2];
  assign D3     = d_q[3];
  assign D4     = d_q[4];
  assign D5     = d_q[5];
  assign D6     = d_q[6];
  assign D7     = d_q[7];
  assign slot   = cur_slot;
  assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb/tb_tdm_demux_1x8.sv - directed scoreboard bench for tdm_demux_1x8
module tb_tdm_demux_1x8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       valid;
  logic       sync;
  logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7;
  logic       frame_valid;
  logic       sync_err;
  logic [2:0] slot;
  logic       locked;

  tdm_demux_1x8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .valid       (valid),
    .sync        (sync),
    .D0          (D0),
    .D1          (D1),
    .D2          (D2),
    .D3          (D3),
    .D4          (D4),
    .D5          (D5),
    .D6          (D6),
    .D7          (D7),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .slot        (slot),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  int          cyc    = 0;
  int          fv_cnt = 0;
  int          se_cnt = 0;
  int          last_fv  = -1;
  int          prev_fv  = -1;
  logic [63:0] exp_q [$];

  function automatic logic [63:0] dvec();
    return {D7, D6, D5, D4, D3, D2, D1, D0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive, clock, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    logic [63:0] e;
    valid = v; sync = s; din = d;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      prev_fv = last_fv;
      last_fv = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_publish", dvec(), 64'hx);
      end else begin
        e = exp_q.pop_front();
        chk("frame_data", dvec(), e);
      end
    end
    if (sync_err === 1'b1) begin
      se_cnt++;
      chk("fv_with_sync_err", {63'd0, frame_valid}, 64'd0);
    end
  endtask

  task automatic frame(input logic [7:0] b [8], input logic first_sync);
    for (int i = 0; i < 8; i++) step(1'b1, first_sync && (i == 0), b[i]);
  endtask

  function automatic logic [63:0] pack(input logic [7:0] b [8]);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = b[i];
    return r;
  endfunction

  logic [7:0] fr [8];
  int         fv_before;
  logic [2:0] slot_hold;

  initial begin
    rst = 1'b1; valid = 1'b0; sync = 1'b0; din = '0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hEE);
    chk("rst_dout", dvec(), 64'd0);
    chk("rst_fv", {63'd0, frame_valid}, 64'd0);
    chk("rst_se", {63'd0, sync_err}, 64'd0);
    chk("rst_slot", {61'd0, slot}, 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    rst = 1'b0;

    // Frame 1: walking ones, sync on first beat.
    fr = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    exp_q.push_back(pack(fr));
    step(1'b1, 1'b1, fr[0]);
    chk("lock_after_sync", {63'd0, locked}, 64'd1);
    chk("slot_after_sync", {61'd0, slot}, 64'd1);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, fr[i]);
    chk("t1_fv_pulse", {63'd0, frame_valid}, 64'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("t1_fv_one_cycle", {63'd0, frame_valid}, 64'd0);
    chk("t1_hold", dvec(), 64'h8040201008040201);

    // Frame 2: unsynced junk in HUNT is ignored.
    rst = 1'b1; step(1'b0, 1'b0, 8'h00); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'hFF);
      chk("hunt_slot", {61'd0, slot}, 64'd0);
    end
    chk("hunt_unlocked", {63'd0, locked}, 64'd0);
    fv_before = fv_cnt;
    for (int i = 0; i < 8; i++) fr[i] = 8'hA0 + 8'(i);
    exp_q.push_back(pack(fr));
    frame(fr, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("t2_one_pulse", 64'(fv_cnt - fv_before), 64'd1);

    // Frame 3: mid-frame sync discards the partial frame.
    step(1'b1, 1'b0, 8'hC1);
    step(1'b1, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 8'hC3);
    step(1'b1, 1'b1, 8'h55);
    chk("t3_sync_err", {63'd0, sync_err}, 64'd1);
    chk("t3_slot_one", {61'd0, slot}, 64'd1);
    exp_q.push_back({8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55});
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 8'(i * 8'h11));
    step(1'b0, 1'b0, 8'h00);
    chk("t3_err_count", 64'(se_cnt), 64'd1);

    // Frame 4: valid toggles every cycle; slot frozen during stalls.
    for (int i = 0; i < 8; i++) fr[i] = 8'hB0 + 8'(i);
    exp_q.push_back(pack(fr));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, fr[i]);
      slot_hold = slot;
      step(1'b0, 1'b1, 8'hEE);
      chk("stall_slot", {61'd0, slot}, {61'd0, slot_hold});
    end

    // Frames 5-6: back-to-back, sync only on the first.
    for (int i = 0; i < 8; i++) fr[i] = 8'hC8 + 8'(i);
    exp_q.push_back(pack(fr));
    frame(fr, 1'b1);
    for (int i = 0; i < 8; i++) fr[i] = 8'hD0 + 8'(i * 3);
    exp_q.push_back(pack(fr));
    frame(fr, 1'b0);
    chk("b2b_spacing", 64'(last_fv - prev_fv), 64'd8);

    // Reset after slot 4 of a locked frame.
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 8'h90 + 8'(i));
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h95);
    rst = 1'b0;
    chk("midrst_dout", dvec(), 64'd0);
    chk("midrst_slot", {61'd0, slot}, 64'd0);
    chk("midrst_locked", {63'd0, locked}, 64'd0);
    fv_before = fv_cnt;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    chk("post_rst_ignored", 64'(fv_cnt - fv_before), 64'd0);
    chk("post_rst_unlocked", {63'd0, locked}, 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("total_pulses", 64'(fv_cnt), 64'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
